// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// Every operation takes 32 single-bit iterations plus one sign-correction
// cycle, so the latency is fixed at 33 cycles. Requests and results use
// valid/ready handshakes.
module muldiv_unit (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] opr_a_i,
    input  logic [31:0] opr_b_i,
    input  logic [2:0]  op_i,
    input  logic        flush_i,
    output logic        res_valid_o,
    input  logic        res_ready_i,
    output logic [31:0] res_o
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    state_e      state_q, state_d;
    logic        sync_q;
    logic [2:0]  op_q,    op_d;
    logic [31:0] a_q,     a_d;      // multiplicand or divisor magnitude
    logic [63:0] acc_q,   acc_d;    // {product hi, multiplier} or {remainder, quotient}
    logic        neg_q,   neg_d;    // negate the selected result at the end
    logic [5:0]  cnt_q,   cnt_d;
    logic [31:0] res_q,   res_d;

    // Operand preparation at accept time
    logic        sgn_a, sgn_b, neg_a, neg_b;
    logic [31:0] mag_a, mag_b;
    // Iteration and finishing terms
    logic [32:0] mul_sum, div_sh, div_diff;
    logic [63:0] prod;
    logic [31:0] div_sel;
    logic        accept;

    assign req_ready_o = (state_q == S_IDLE);
    assign res_valid_o = (state_q == S_DONE);
    assign res_o       = res_q;

    // One flop releases the internal reset one edge after rst_n_i rises.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) sync_q <= 1'b0;
        else          sync_q <= 1'b1;
    end

    // Next-state, datapath iteration and result formation.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
        res_d   = res_q;

        sgn_a = (op_i == OP_MUL) || (op_i == OP_MULH) || (op_i == OP_MULHSU) ||
                (op_i == OP_DIV) || (op_i == OP_REM);
        sgn_b = (op_i == OP_MUL) || (op_i == OP_MULH) ||
                (op_i == OP_DIV) || (op_i == OP_REM);
        neg_a = sgn_a & opr_a_i[31];
        neg_b = sgn_b & opr_b_i[31];
        mag_a = neg_a ? -opr_a_i : opr_a_i;
        mag_b = neg_b ? -opr_b_i : opr_b_i;

        mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, a_q} : 33'd0);
        div_sh   = {acc_q[63:32], acc_q[31]};
        div_diff = div_sh - {1'b0, a_q};
        prod     = neg_q ? -acc_q : acc_q;
        div_sel  = op_q[1] ? acc_q[63:32] : acc_q[31:0];

        accept = req_valid_i & (state_q == S_IDLE) & ~flush_i & sync_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_CALC;
                    op_d    = op_i;
                    cnt_d   = 6'd0;
                    if (op_i[2]) begin
                        a_d   = mag_b;
                        acc_d = {32'd0, mag_a};
                        // Quotient of x/0 stays all-ones; remainder follows the dividend.
                        neg_d = op_i[1] ? neg_a : ((neg_a ^ neg_b) & (opr_b_i != 32'd0));
                    end else begin
                        a_d   = mag_a;
                        acc_d = {32'd0, mag_b};
                        neg_d = neg_a ^ neg_b;
                    end
                end
            end
            S_CALC: begin
                if (cnt_q != 6'd32) begin
                    cnt_d = cnt_q + 6'd1;
                    if (op_q[2]) begin
                        if (!div_diff[32]) acc_d = {div_diff[31:0], acc_q[30:0], 1'b1};
                        else               acc_d = {div_sh[31:0],   acc_q[30:0], 1'b0};
                    end else begin
                        acc_d = {mul_sum, acc_q[31:1]};
                    end
                end else begin
                    state_d = S_DONE;
                    if (op_q[2])              res_d = neg_q ? -div_sel : div_sel;
                    else if (op_q == OP_MUL)  res_d = prod[31:0];
                    else                      res_d = prod[63:32];
                end
            end
            S_DONE: begin
                if (res_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (flush_i) state_d = S_IDLE;
    end

    // State and datapath registers, cleared asynchronously by reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            op_q    <= 3'd0;
            a_q     <= 32'd0;
            acc_q   <= 64'd0;
            neg_q   <= 1'b0;
            cnt_q   <= 6'd0;
            res_q   <= 32'd0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

endmodule
